// File: rtl/hevc_actor_pkg.sv
// Shared helpers for the HEVC butterfly dataflow actors: tag sizing, saturation
// and rounding-offset constants.
package hevc_actor_pkg;

  // At least one tag bit so single-flux instances still elaborate.
  function automatic int unsigned tag_width(input int unsigned flux);
    return (flux > 1) ? $clog2(flux) : 1;
  endfunction

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int unsigned        out_width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

  function automatic logic [63:0] round_ofs(input int unsigned shift);
    return 64'd1 << (shift - 1);
  endfunction

endpackage

// File: rtl/flux_rr_arbiter.sv
// Combinational round-robin flux selector: first eligible flux after ptr,
// searching ptr+1, ptr+2, ... modulo FLUX.
module flux_rr_arbiter
  import hevc_actor_pkg::*;
#(
  parameter int unsigned  FLUX      = 2,
  localparam int unsigned TAG_WIDTH = tag_width(FLUX)
) (
  input  logic [FLUX-1:0]      eligible,
  input  logic [TAG_WIDTH-1:0] ptr,
  output logic [TAG_WIDTH-1:0] sel,
  output logic                 found
);

  always_comb begin
    int unsigned idx;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= FLUX; i++) begin
      idx = (32'(ptr) + i) % FLUX;
      // Constant-index scan keeps the bit select in range for any FLUX.
      for (int unsigned j = 0; j < FLUX; j++) begin
        if (!found && (j == idx) && eligible[j]) begin
          found = 1'b1;
          sel   = TAG_WIDTH'(j);
        end
      end
    end
  end

endmodule

// File: rtl/shift_clip_18.sv
// Tagged multi-flux actor: rounding arithmetic right shift of 18-bit sums followed by
// saturation to OUT_WIDTH, as a two-stage pipeline with round-robin flux arbitration.
module shift_clip_18
  import hevc_actor_pkg::*;
#(
  parameter int unsigned  FLUX       = 2,
  parameter int unsigned  DATA_WIDTH = 18,
  parameter int unsigned  SHIFT      = 1,
  parameter int unsigned  OUT_WIDTH  = 16,
  localparam int unsigned TAG_WIDTH  = tag_width(FLUX)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [FLUX-1:0]               read_port_sum_empty,
  input  logic [TAG_WIDTH+DATA_WIDTH-1:0] read_port_sum_dout,
  output logic [FLUX-1:0]               read_port_sum_read,
  input  logic [FLUX-1:0]               write_port_res_full,
  output logic                          write_port_res_write,
  output logic [TAG_WIDTH+OUT_WIDTH-1:0]  write_port_res_din
);

  logic [FLUX-1:0]               eligible;
  logic [TAG_WIDTH-1:0]          sel;
  logic                          found;
  logic                          pop;
  logic                          a_adv;
  logic                          full_b;

  logic [TAG_WIDTH-1:0]          rr_ptr_q;
  logic                          valid_a_q;
  logic [TAG_WIDTH-1:0]          tag_a_q;
  logic signed [DATA_WIDTH:0]    sum_a_q;
  logic signed [DATA_WIDTH:0]    sum_a_d;
  logic                          valid_b_q;
  logic [TAG_WIDTH-1:0]          tag_b_q;
  logic signed [OUT_WIDTH-1:0]   res_b_q;
  logic signed [OUT_WIDTH-1:0]   res_b_d;
  logic signed [DATA_WIDTH:0]    shifted;
  logic signed [DATA_WIDTH-1:0]  data;
  logic                          unused_dout_tag;

  assign eligible = ~read_port_sum_empty & ~write_port_res_full;

  flux_rr_arbiter #(
    .FLUX(FLUX)
  ) u_arb (
    .eligible(eligible),
    .ptr     (rr_ptr_q),
    .sel     (sel),
    .found   (found)
  );

  // The bundle presents the head word of the flux being popped; the tag comes from sel.
  assign data            = read_port_sum_dout[DATA_WIDTH-1:0];
  assign unused_dout_tag = ^read_port_sum_dout[TAG_WIDTH+DATA_WIDTH-1:DATA_WIDTH];

  always_comb begin
    full_b               = write_port_res_full[tag_b_q];
    write_port_res_write = valid_b_q & ~full_b;
    a_adv                = valid_a_q & (~valid_b_q | write_port_res_write);
    pop                  = found & (~valid_a_q | a_adv) & ~rst;
    read_port_sum_read   = '0;
    if (pop) begin
      read_port_sum_read = FLUX'(1) << sel;
    end
    write_port_res_din = '0;
    if (valid_b_q) begin
      write_port_res_din = {tag_b_q, res_b_q};
    end
  end

  // One extra bit of headroom so the rounding add cannot wrap.
  assign sum_a_d = {data[DATA_WIDTH-1], data} + (DATA_WIDTH + 1)'(round_ofs(SHIFT));
  assign shifted = sum_a_q >>> SHIFT;
  assign res_b_d = OUT_WIDTH'(sat_signed(64'(shifted), OUT_WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= TAG_WIDTH'(FLUX - 1);
      valid_a_q <= 1'b0;
      tag_a_q   <= '0;
      sum_a_q   <= '0;
      valid_b_q <= 1'b0;
      tag_b_q   <= '0;
      res_b_q   <= '0;
    end else begin
      if (pop) begin
        rr_ptr_q <= sel;
        tag_a_q  <= sel;
        sum_a_q  <= sum_a_d;
      end
      valid_a_q <= pop | (valid_a_q & ~a_adv);
      if (a_adv) begin
        tag_b_q <= tag_a_q;
        res_b_q <= res_b_d;
      end
      valid_b_q <= a_adv | (valid_b_q & ~write_port_res_write);
    end
  end

endmodule

// File: tb/tb_shift_clip_18.sv
// Scoreboard bench for shift_clip_18: FIFO models on both sides, per-flux expected queues
// filled at stimulus time and drained by a monitor on every push.
module tb_shift_clip_18;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  empty;
  logic [18:0] dout;
  logic [1:0]  read;
  logic [1:0]  full;
  logic        write;
  logic [16:0] din;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [17:0] in0[$];
  logic [17:0] in1[$];
  logic [15:0] exp0[$];
  logic [15:0] exp1[$];
  int          inflight0 = 0;
  int          inflight1 = 0;
  logic [17:0] head0 = '0;
  logic [17:0] head1 = '0;
  logic        mon_tag;
  logic [15:0] mon_res;

  always #5 clk = ~clk;

  shift_clip_18 dut (
    .clk                 (clk),
    .rst                 (rst),
    .read_port_sum_empty (empty),
    .read_port_sum_dout  (dout),
    .read_port_sum_read  (read),
    .write_port_res_full (full),
    .write_port_res_write(write),
    .write_port_res_din  (din)
  );

  // FWFT bundle: present the head of whichever flux is being popped.
  assign dout = read[1] ? {1'b1, head1} : {1'b0, head0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic refresh();
    empty[0] = (in0.size() == 0);
    empty[1] = (in1.size() == 0);
    head0    = (in0.size() > 0) ? in0[0] : '0;
    head1    = (in1.size() > 0) ? in1[0] : '0;
  endtask

  task automatic push(input int f, input int d, input int e);
    if (f == 0) begin
      in0.push_back(18'(d));
      exp0.push_back(16'(e));
    end else begin
      in1.push_back(18'(d));
      exp1.push_back(16'(e));
    end
  endtask

  task automatic wait_write(input string name, input int budget);
    int t;
    t = 0;
    while (!write && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(name, write, 1'b1);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((in0.size() + in1.size() + exp0.size() + exp1.size()) != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({name, "_left"}, in0.size() + in1.size() + exp0.size() + exp1.size(), 0);
    check({name, "_inflight"}, inflight0 + inflight1, 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Input FIFO pops and output monitor, sampled on the edge with pre-edge values.
  always begin
    @(posedge clk);
    if (!rst) begin
      if (read != 2'b00) check("read_onehot", 32'($onehot(read)), 1);
      if (read[0]) begin
        check("read_f0_nonempty", 32'(in0.size() > 0), 1);
        if (in0.size() > 0) void'(in0.pop_front());
        inflight0++;
      end
      if (read[1]) begin
        check("read_f1_nonempty", 32'(in1.size() > 0), 1);
        if (in1.size() > 0) void'(in1.pop_front());
        inflight1++;
      end
      if (write) begin
        mon_tag = din[16];
        mon_res = din[15:0];
        check("write_not_full", full[mon_tag], 1'b0);
        if (mon_tag == 1'b0) begin
          if (exp0.size() == 0) check("push_f0_unexpected", 1, 0);
          else check("push_f0_data", mon_res, exp0.pop_front());
          inflight0--;
        end else begin
          if (exp1.size() == 0) check("push_f1_unexpected", 1, 0);
          else check("push_f1_data", mon_res, exp1.pop_front());
          inflight1--;
        end
      end
    end
    #1 refresh();
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    int          t;
    int          c0;
    int          reads;
    int          writes;
    int          alt_err;
    int          first_w;
    int          last_w;
    int          n0;
    int          n1;
    logic [1:0]  prev;
    logic [16:0] held;
    int          d_tab[16];
    int          e_tab[16];

    d_tab = '{0, 1, 2, 3, -1, -2, -3, 100, -100, 7, 65535, -65536, -65537, 65533, 1000, -7};
    e_tab = '{0, 1, 1, 2, 0, -1, -1, 50, -50, 4, 32767, -32768, -32768, 32767, 500, -3};

    full = 2'b00;
    refresh();
    repeat (3) @(negedge clk);
    check("reset_read", read, 2'b00);
    check("reset_write", write, 1'b0);
    check("reset_din", din, 17'h0);
    rst = 1'b0;

    // Basic rounding and two-cycle latency.
    @(negedge clk);
    push(0, 5, 3);
    t = 0;
    while (!read[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("lat_read0_seen", read[0], 1'b1);
    c0 = cyc;
    wait_write("lat_write_seen", 20);
    check("latency_cycles", cyc - c0, 2);
    push(0, -5, -2);
    drain("basic");

    // Saturation corners.
    push(0, 131071, 32767);
    push(1, -131072, -32768);
    push(0, 65534, 32767);
    drain("sat");

    // Both fluxes loaded: alternating reads, back-to-back writes.
    @(negedge clk);
    for (int i = 0; i < 16; i++) push(i % 2, d_tab[i], e_tab[i]);
    reads = 0; writes = 0; alt_err = 0; first_w = 0; last_w = 0; prev = 2'b00; t = 0;
    while ((reads < 16 || writes < 16) && t < 80) begin
      @(negedge clk);
      t++;
      if (read != 2'b00) begin
        if (reads > 0 && read == prev) alt_err++;
        prev = read;
        reads++;
      end
      if (write) begin
        if (writes == 0) first_w = cyc;
        last_w = cyc;
        writes++;
      end
    end
    check("alt_reads", reads, 16);
    check("alt_order_errors", alt_err, 0);
    check("alt_writes", writes, 16);
    check("alt_write_span", last_w - first_w, 15);
    drain("alt");

    // Output flux 1 blocked while its word sits in B.
    push(1, 10, 5);
    push(1, 11, 6);
    push(1, 12, 6);
    push(1, -11, -5);
    wait_write("stall_first_write", 30);
    full[1] = 1'b1;
    held = din;
    check("stall_b_word", held, {1'b1, 16'd5});
    n0 = 0; n1 = 0; t = 0;
    repeat (10) begin
      @(negedge clk);
      if (write) n0++;
      if (read != 2'b00) n1++;
      if (din != held) t++;
    end
    check("stall_writes", n0, 0);
    check("stall_reads", n1, 0);
    check("stall_din_changes", t, 0);
    check("stall_inflight", inflight1, 2);
    full[1] = 1'b0;
    drain("stall");

    // Flux 0 output full: only flux 1 is served.
    full[0] = 1'b1;
    push(0, 20, 10);
    push(0, 21, 11);
    push(1, 30, 15);
    push(1, -30, -15);
    n0 = 0; n1 = 0;
    repeat (12) begin
      @(negedge clk);
      if (read[0]) n0++;
      if (read[1]) n1++;
    end
    check("full0_reads0", n0, 0);
    check("full0_reads1", n1, 2);
    full[0] = 1'b0;
    drain("full0");

    // Reset with both stages holding flux 1 words.
    push(1, 40, 20);
    push(1, 50, 25);
    push(1, 60, 30);
    wait_write("rst_first_write", 30);
    full[1] = 1'b1;
    push(0, 70, 35);
    repeat (2) @(negedge clk);
    check("rst_pre_inflight", inflight1, 2);
    rst = 1'b1;
    #1;
    check("rst_read", read, 2'b00);
    check("rst_write", write, 1'b0);
    check("rst_din", din, 17'h0);
    void'(exp1.pop_front());
    void'(exp1.pop_front());
    inflight1 = 0;
    full[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_first_read", read, 2'b01);
    drain("rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
